// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  // fetch stage drives the request, memory answers
  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ready);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds PC, fetches over req/ready, presents a
// stable Instr to decode and computes next PC from branch/jump decisions.
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  // initial retire count; normally 0
  parameter logic [31:0] RESET_RETIRE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_if.master     imem,
  output logic [31:0] Instr,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PcPlus4,
  input  logic        PCSrc,
  input  logic        Jump,
  input  logic        stall,
  output logic [31:0] retire_cnt
);

  typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] cnt_q;
  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] next_pc_d;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // next PC: jump has priority over a taken branch
  always_comb begin
    next_pc_d = pc_plus4;
    if (Jump)       next_pc_d = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    else if (PCSrc) next_pc_d = pc_plus4 + br_off;
  end

  // FETCH/EXEC sequencing; PC and retire count move only on advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      cnt_q   <= RESET_RETIRE;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem.imem_ready) begin
            instr_q <= imem.imem_rdata;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (!stall) begin
            pc_q    <= next_pc_d;
            cnt_q   <= cnt_q + 32'd1;
            state_q <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = pc_q;
  assign instr_valid    = (state_q == EXEC);
  assign Instr          = instr_q;
  assign PC             = pc_q;
  assign PcPlus4        = pc_plus4;
  assign retire_cnt     = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: three instances with different reset PCs
// share one queue of expected fetch addresses, popped by a negedge monitor.
module tb_fetch_unit;

  localparam int N = 3;
  localparam logic [31:0] RPC [N] = '{32'h0000_0000, 32'h4000_0010, 32'hFFFF_FFFC};
  localparam logic [31:0] RRT [N] = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};

  typedef struct {
    int          idx;
    logic [31:0] addr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] rdata  [N];
  logic        ready  [N];
  logic        pcsrc  [N];
  logic        jump   [N];
  logic        stall  [N];
  logic        req_w  [N];
  logic [31:0] addr_w [N];
  logic [31:0] instr_w[N];
  logic        vld_w  [N];
  logic [31:0] pc_w   [N];
  logic [31:0] pp4_w  [N];
  logic [31:0] cnt_w  [N];

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  for (genvar g = 0; g < N; g++) begin : gi
    fetch_if bus ();
    assign bus.imem_rdata = rdata[g];
    assign bus.imem_ready = ready[g];
    assign req_w[g]       = bus.imem_req;
    assign addr_w[g]      = bus.imem_addr;

    fetch_unit #(.RESET_PC(RPC[g]), .RESET_RETIRE(RRT[g])) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem        (bus),
      .Instr       (instr_w[g]),
      .instr_valid (vld_w[g]),
      .PC          (pc_w[g]),
      .PcPlus4     (pp4_w[g]),
      .PCSrc       (pcsrc[g]),
      .Jump        (jump[g]),
      .stall       (stall[g]),
      .retire_cnt  (cnt_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input logic [31:0] a);
    exp_t e;
    e.idx  = idx;
    e.addr = a;
    exp_q.push_back(e);
  endtask

  // monitor: every accepted fetch must match the next expected address
  always @(negedge clk) begin
    if (rst_n) begin
      for (int g = 0; g < N; g++) begin
        if (req_w[g] && ready[g]) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL fetch_unexpected: dut%0d got %h expected no fetch", g, addr_w[g]);
          end else begin
            mon_e = exp_q.pop_front();
            chk("fetch_dut", 32'(g), 32'(mon_e.idx));
            chk("fetch_addr", addr_w[g], mon_e.addr);
          end
        end
      end
    end
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nreq, nvld;
    rst_n = 1'b0;
    for (int g = 0; g < N; g++) begin
      rdata[g] = 32'h0; ready[g] = 1'b0; pcsrc[g] = 1'b0; jump[g] = 1'b0; stall[g] = 1'b0;
    end
    ready[0] = 1'b1;
    step(); step();

    // reset state
    chk("rst_pc0",    pc_w[0],    32'h0);
    chk("rst_vld0",   32'(vld_w[0]), 32'h0);
    chk("rst_cnt0",   cnt_w[0],   32'h0);
    chk("rst_instr0", instr_w[0], 32'h0);
    chk("rst_pc1",    pc_w[1],    32'h4000_0010);
    chk("rst_pc2",    pc_w[2],    32'hFFFF_FFFC);

    // 1: zero-wait sequential fetch
    push(0, 32'h0); push(0, 32'h4); push(0, 32'h8); push(0, 32'hC);
    rst_n = 1'b1;
    #1;
    chk("rel_req0",  32'(req_w[0]), 32'h1);
    chk("rel_addr0", addr_w[0], 32'h0);
    repeat (8) step();
    ready[0] = 1'b0;
    chk("seq_cnt", cnt_w[0], 32'd4);
    chk("seq_pc",  pc_w[0],  32'h10);

    // 2: jump to 0x100, branch self-loop, branch +3 words
    rdata[0] = 32'h0000_0040; jump[0] = 1'b1; ready[0] = 1'b1;
    push(0, 32'h10); push(0, 32'h100);
    step();
    chk("j_instr", instr_w[0], 32'h0000_0040);
    chk("j_vld",   32'(vld_w[0]), 32'h1);
    chk("j_pp4",   pp4_w[0], 32'h14);
    rdata[0] = 32'h0000_FFFF;
    step();
    chk("j_pc", pc_w[0], 32'h100);
    jump[0] = 1'b0; pcsrc[0] = 1'b1;
    push(0, 32'h100);
    step();
    chk("b_instr_neg", instr_w[0], 32'h0000_FFFF);
    rdata[0] = 32'h0000_0003;
    step();
    chk("b_selfloop_pc", pc_w[0], 32'h100);
    push(0, 32'h110);
    step();
    chk("b_instr_pos", instr_w[0], 32'h0000_0003);
    step();
    chk("b_fwd_pc", pc_w[0], 32'h110);
    ready[0] = 1'b0; pcsrc[0] = 1'b0; rdata[0] = 32'h1234_5678;

    // 4: 3 wait states then 4 stall cycles in EXEC
    nreq = 0; nvld = 0;
    for (int i = 0; i < 9; i++) begin
      if (req_w[0]) nreq++;
      if (vld_w[0]) begin
        nvld++;
        chk("stall_instr", instr_w[0], 32'h1234_5678);
        chk("stall_cnt",   cnt_w[0],   32'd7);
      end
      case (i)
        3: begin ready[0] = 1'b1; stall[0] = 1'b1; end
        4: begin ready[0] = 1'b0; jump[0] = 1'b1; pcsrc[0] = 1'b1; end
        6: jump[0] = 1'b0;
        7: pcsrc[0] = 1'b0;
        8: stall[0] = 1'b0;
        default: ;
      endcase
      step();
    end
    chk("stall_nreq", 32'(nreq), 32'd4);
    chk("stall_nvld", 32'(nvld), 32'd5);
    chk("stall_cnt_after", cnt_w[0], 32'd8);
    chk("stall_pc_after",  pc_w[0],  32'h114);
    chk("stall_vld_after", 32'(vld_w[0]), 32'h0);

    // 5a: reset mid-FETCH with ready high
    ready[0] = 1'b1; rst_n = 1'b0;
    #1;
    chk("rf_pc",  pc_w[0],  32'h0);
    chk("rf_cnt", cnt_w[0], 32'h0);
    push(0, 32'h0);
    step();
    chk("rf_vld",   32'(vld_w[0]), 32'h0);
    chk("rf_instr", instr_w[0], 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rf_addr", addr_w[0], 32'h0);
    step();
    chk("rf_first_vld", 32'(vld_w[0]), 32'h1);

    // 5b: reset mid-EXEC, held Instr discarded and not counted
    rst_n = 1'b0;
    #1;
    chk("re_vld",   32'(vld_w[0]), 32'h0);
    chk("re_instr", instr_w[0], 32'h0);
    chk("re_cnt",   cnt_w[0],   32'h0);
    chk("re_pc",    pc_w[0],    32'h0);
    push(0, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("re_post_vld", 32'(vld_w[0]), 32'h1);
    chk("re_post_cnt", cnt_w[0], 32'h0);
    ready[0] = 1'b0;
    step();
    chk("re_adv_cnt", cnt_w[0], 32'd1);
    chk("re_adv_pc",  pc_w[0],  32'h4);

    // 3: jump wins over branch, upper nibble kept from PcPlus4
    push(1, 32'h4000_0010); push(1, 32'h4000_0100);
    rdata[1] = 32'h0000_0040; jump[1] = 1'b1; pcsrc[1] = 1'b1; ready[1] = 1'b1;
    step();
    chk("jp_instr", instr_w[1], 32'h0000_0040);
    step();
    chk("jp_pc", pc_w[1], 32'h4000_0100);
    step();
    ready[1] = 1'b0; jump[1] = 1'b0; pcsrc[1] = 1'b0;

    // 6: PC and retire counter wrap
    chk("wr_pc0",  pc_w[2],  32'hFFFF_FFFC);
    chk("wr_pp40", pp4_w[2], 32'h0);
    chk("wr_cnt0", cnt_w[2], 32'hFFFF_FFFF);
    push(2, 32'hFFFF_FFFC); push(2, 32'h0);
    ready[2] = 1'b1;
    step();
    step();
    chk("wr_pc",  pc_w[2],  32'h0);
    chk("wr_cnt", cnt_w[2], 32'h0);
    chk("wr_pp4", pp4_w[2], 32'h4);
    step();
    ready[2] = 1'b0;
    step();

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
